uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters (2..8); DATA_W, default 8, byte width; START_TO, default 16, cycles allowed for transmitter to assert busy after start; GAP_CYC, default 2, idle cycles between bytes (0 allowed).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_req  input  NUM_REQ  per-requester byte-ready request, level.
REQ-005 i_data  input  NUM_REQ*DATA_W  requester k byte on bits [k*DATA_W +: DATA_W].
REQ-006 o_gnt  output  NUM_REQ  one-hot, one-cycle pulse: requester's byte accepted.
REQ-007 o_done  output  NUM_REQ  one-hot, one-cycle pulse: that requester's byte fully transmitted.
REQ-008 o_err  output  1  one-cycle pulse: start timeout.
REQ-009 o_err_cnt  output  8  saturating timeout count.
REQ-010 o_owner  output  3  index of current/last owner.
REQ-011 o_busy  output  1  high whenever state is not IDLE.
REQ-012 o_tx  output  DATA_W  byte to the UART transmitter.
REQ-013 o_tx_start  output  1  start request to the transmitter, level.
REQ-014 i_tx_busy  input  1  transmitter busy flag.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 States SHALL be IDLE, START, BUSY, GAP.
REQ-017 IDLE: when any i_req bit is high and i_tx_busy=0, SHALL pick a winner, latch its byte into o_tx, pulse o_gnt[winner], set o_owner, set o_tx_start=1, enter START; all in the cycle after the sampling edge (latency 1).
REQ-018 IDLE with i_tx_busy=1 SHALL grant nothing, regardless of i_req.
REQ-019 Arbitration SHALL be round-robin: search from rr_ptr upward, wrapping at NUM_REQ-1 to 0; on grant to k, rr_ptr <= (k+1) mod NUM_REQ.
REQ-020 Only the winner SHALL see o_gnt; losers keep i_req high and are not dropped.
REQ-021 START: o_tx_start SHALL stay 1 and o_tx stable; when i_tx_busy=1 sampled, clear o_tx_start next cycle and enter BUSY.
REQ-022 START timeout: a counter SHALL clear on START entry; if i_tx_busy is still 0 after START_TO cycles in START, SHALL clear o_tx_start, pulse o_err, increment o_err_cnt (saturates at 255), issue no o_done, and enter GAP.
REQ-023 BUSY: when i_tx_busy=0 sampled, SHALL pulse o_done[o_owner] for one cycle and enter GAP.
REQ-024 GAP: SHALL hold GAP_CYC cycles then return to IDLE; GAP_CYC=0 SHALL go directly to IDLE.
REQ-025 Minimum spacing between successive o_gnt pulses SHALL be 3+GAP_CYC cycles.
REQ-026 i_req/i_data SHALL be ignored outside IDLE; the requester may change i_data from the cycle after o_gnt.
REQ-027 A requester whose i_req drops before grant SHALL lose its turn without side effects.
REQ-028 o_tx SHALL hold the last transmitted byte until the next grant.

Reset
REQ-029 On rst: state IDLE, rr_ptr=0, o_gnt=0, o_done=0, o_err=0, o_err_cnt=0, o_owner=0, o_busy=0, o_tx=0, o_tx_start=0, asynchronously.
REQ-030 Reset mid-transfer SHALL drop o_tx_start immediately, with no o_done; after release no grant until i_tx_busy=0.

Verification
REQ-031 Single request: i_req=0001, data[0]=8'hA5; transmitter busy 10 cycles -> o_gnt=0001 one cycle after request, o_tx=8'hA5, o_tx_start high until busy, o_done=0001 once.
REQ-032 Contention: i_req=1111 held -> grant order 0,1,2,3,0; no requester granted twice before all others.
REQ-033 Wrap: rr_ptr=3, i_req=1001 -> grant 3, then 0.
REQ-034 Timeout: i_tx_busy held 0 -> o_err pulse after START_TO=16 cycles, o_err_cnt=1, no o_done, IDLE after GAP; 300 timeouts -> o_err_cnt=255.
REQ-035 Busy at idle: i_tx_busy=1, i_req=0010 -> no o_gnt until busy falls, then grant 1 next cycle.
REQ-036 Reset in BUSY: rst pulse -> o_tx_start=0, o_busy=0 immediately, no o_done, rr_ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several byte producers share one UART transmitter.
// Every output is a flop; the FSM computes next values and one register stage holds them.
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int START_TO = 16,
  parameter int GAP_CYC  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_data,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_done,
  output logic                      o_err,
  output logic [7:0]                o_err_cnt,
  output logic [2:0]                o_owner,
  output logic                      o_busy,
  output logic [DATA_W-1:0]         o_tx,
  output logic                      o_tx_start,
  input  logic                      i_tx_busy
);

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  // With no gap requested, a finished or timed-out byte returns straight to IDLE.
  localparam state_t AFTER_XFER = (GAP_CYC == 0) ? IDLE : GAP;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          rr_q, rr_d;
  logic [2:0]          winner;
  logic                found;
  logic [NUM_REQ-1:0]  req_rot;
  int                  idx;

  logic [NUM_REQ-1:0]  gnt_d, done_d;
  logic                err_d, busy_d, tx_start_d;
  logic [7:0]          err_cnt_d;
  logic [2:0]          owner_d;
  logic [DATA_W-1:0]   tx_d;

  // Round-robin search: first requester at or above rr_q, wrapping to 0.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    idx     = 0;
    req_rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      req_rot = i_req >> idx;
      if (!found && req_rot[0]) begin
        found  = 1'b1;
        winner = 3'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    gnt_d      = '0;
    done_d     = '0;
    err_d      = 1'b0;
    err_cnt_d  = o_err_cnt;
    owner_d    = o_owner;
    tx_d       = o_tx;
    tx_start_d = o_tx_start;

    case (state_q)
      IDLE: begin
        if (found && !i_tx_busy) begin
          gnt_d      = NUM_REQ'(1) << winner;
          owner_d    = winner;
          tx_d       = DATA_W'(i_data >> (int'(winner) * DATA_W));
          tx_start_d = 1'b1;
          rr_d       = (int'(winner) == NUM_REQ - 1) ? 3'd0 : winner + 3'd1;
          cnt_d      = '0;
          state_d    = START;
        end
      end
      START: begin
        if (i_tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = BUSY;
        end else if (cnt_q == CNT_W'(START_TO - 1)) begin
          // Transmitter never acknowledged: abandon the byte without a done pulse.
          tx_start_d = 1'b0;
          err_d      = 1'b1;
          if (o_err_cnt != 8'hFF) err_cnt_d = o_err_cnt + 8'd1;
          cnt_d      = '0;
          state_d    = AFTER_XFER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY: begin
        if (!i_tx_busy) begin
          done_d  = NUM_REQ'(1) << o_owner;
          cnt_d   = '0;
          state_d = AFTER_XFER;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) state_d = IDLE;
        else                              cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_q       <= '0;
      o_gnt      <= '0;
      o_done     <= '0;
      o_err      <= 1'b0;
      o_err_cnt  <= '0;
      o_owner    <= '0;
      o_busy     <= 1'b0;
      o_tx       <= '0;
      o_tx_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      o_gnt      <= gnt_d;
      o_done     <= done_d;
      o_err      <= err_d;
      o_err_cnt  <= err_cnt_d;
      o_owner    <= owner_d;
      o_busy     <= busy_d;
      o_tx       <= tx_d;
      o_tx_start <= tx_start_d;
    end
  end

endmodule
